// File: rtl/systolic_feeder.sv
// Skews two stored 4x4 operand matrices onto the west and north edges of a
// 4x4 systolic array, then flushes zeros for DRAIN cycles and pulses done.
module systolic_feeder #(
    parameter int DW    = 32,
    parameter int DRAIN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] inp_west0,
    output logic [DW-1:0] inp_west1,
    output logic [DW-1:0] inp_west2,
    output logic [DW-1:0] inp_west3,
    output logic [DW-1:0] inp_north0,
    output logic [DW-1:0] inp_north1,
    output logic [DW-1:0] inp_north2,
    output logic [DW-1:0] inp_north3
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    t_q, t_d;
    logic [3:0]    drain_q, drain_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] a_q [16];
    logic [DW-1:0] a_d [16];
    logic [DW-1:0] b_q [16];
    logic [DW-1:0] b_d [16];
    logic [DW-1:0] west_q [4];
    logic [DW-1:0] west_d [4];
    logic [DW-1:0] north_q [4];
    logic [DW-1:0] north_d [4];
    logic          stream_out;

    always_comb begin
        int k;
        k          = 0;
        state_d    = state_q;
        t_d        = t_q;
        drain_d    = drain_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        stream_out = 1'b0;
        a_d        = a_q;
        b_d        = b_q;

        // The write lands in a_d/b_d so a same-edge start streams the new value.
        if (wr_en && !busy_q) begin
            if (wr_sel) b_d[wr_addr] = wr_data;
            else        a_d[wr_addr] = wr_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_STREAM;
                    t_d        = 3'd0;
                    busy_d     = 1'b1;
                    stream_out = 1'b1;
                end
            end
            ST_STREAM: begin
                if (t_q == 3'd6) begin
                    state_d = ST_DRAIN;
                    drain_d = 4'd0;
                end else begin
                    t_d        = t_q + 3'd1;
                    stream_out = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 4'(DRAIN - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                t_d     = 3'd0;
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < 4; i++) begin
            west_d[i]  = '0;
            north_d[i] = '0;
            if (stream_out) begin
                k = int'(t_d) - i;
                if (k >= 0 && k <= 3) begin
                    west_d[i]  = a_d[4'(i * 4 + k)];
                    north_d[i] = b_d[4'(k * 4 + i)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            west_q  <= west_d;
            north_q <= north_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign inp_west0  = west_q[0];
    assign inp_west1  = west_q[1];
    assign inp_west2  = west_q[2];
    assign inp_west3  = west_q[3];
    assign inp_north0 = north_q[0];
    assign inp_north1 = north_q[1];
    assign inp_north2 = north_q[2];
    assign inp_north3 = north_q[3];

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DW, default 32, meaning the operand data width.
REQ-002 SHALL have parameter DRAIN, default 4, meaning the number of zero-flush cycles after the last skewed operand; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port wr_en  input  1  operand write strobe.
REQ-006 SHALL have port wr_sel  input  1  0 = matrix A (west operands), 1 = matrix B (north operands).
REQ-007 SHALL have port wr_addr  input  4  element index row*4+col.
REQ-008 SHALL have port wr_data  input  DW  element value.
REQ-009 SHALL have port start  input  1  single-cycle request to stream the stored A and B.
REQ-010 SHALL have port busy  output  1  high while streaming or draining.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the drain completes.
REQ-012 SHALL have ports inp_west0..inp_west3  output  DW each  skewed row operands for the array's west edge.
REQ-013 SHALL have ports inp_north0..inp_north3  output  DW each  skewed column operands for the array's north edge.

Function
REQ-014 SHALL hold A[4][4] and B[4][4] in internal registers; the write occurs when wr_en is high at a clock edge and busy is low.
REQ-015 SHALL ignore wr_en while busy is high; the stored matrices are unchanged.
REQ-016 SHALL implement states IDLE, STREAM, DRAIN, DONE.
REQ-017 IDLE->STREAM SHALL occur at edge e when start=1; step counter t=0 at that edge.
REQ-018 In STREAM, SHALL advance t by 1 per edge over t=0..6 (2*4-1 steps); STREAM->DRAIN SHALL occur at the edge after t=6.
REQ-019 For step t, SHALL drive inp_west_i = A[i][t-i] when 0<=t-i<=3, else 0.
REQ-020 For step t, SHALL drive inp_north_j = B[t-j][j] when 0<=t-j<=3, else 0.
REQ-021 All data outputs SHALL be registered: step-t values are valid during the cycle following edge e+t.
REQ-022 In DRAIN, SHALL hold all data outputs at 0 for exactly DRAIN cycles, then go to DONE.
REQ-023 In DONE, SHALL assert done for one cycle, at the cycle following edge e+7+DRAIN, then return to IDLE.
REQ-024 SHALL assert busy from the cycle following edge e through the last DRAIN cycle; busy SHALL be low in DONE and IDLE.
REQ-025 SHALL ignore start when not in IDLE, including start asserted in the DONE cycle.
REQ-026 When wr_en and start are both high in IDLE at the same edge, SHALL perform the write and SHALL begin streaming; step-0 outputs SHALL reflect the newly written value.
REQ-027 In IDLE and DONE, SHALL drive all data outputs to 0.
REQ-028 SHALL stream the stored matrices unchanged on repeated starts; matrices persist until overwritten or reset.

Reset
REQ-029 rst high SHALL asynchronously force state IDLE, t=0, drain counter 0, busy=0, done=0, all inp_west*/inp_north*=0, and all A/B elements=0.
REQ-030 rst asserted mid-STREAM or mid-DRAIN SHALL abort with no done pulse; after release, the block SHALL accept start normally.

Verification
REQ-031 A[i][k]=4i+k+1, B[k][j]=16+4k+j, start -> step 0: west0=1, north0=16, other outputs 0; step 3: west3=13, north3=19, west0=4; step 6: west3=16, north3=31.
REQ-032 Same load, DRAIN=4 -> busy high exactly 11 cycles, done high exactly 1 cycle at e+11, and all data outputs 0 during the drain.
REQ-033 wr_en with wr_sel=0, wr_addr=0, data=99 during STREAM, then a second start -> the second stream shows west0=1 at step 0, not 99.
REQ-034 start pulsed at step 2 and in the DONE cycle -> no restart and no extra done; the stream completes identically.
REQ-035 rst pulsed at step 4 -> all outputs 0 immediately and no done; a subsequent start streams all-zero matrices and produces done.
REQ-036 wr_en and start at the same IDLE edge with A[0][0]=7 -> west0=7 at step 0.
